// File: rtl/ro_odometer_ctrl.sv
// ro_odometer_ctrl: stress / settle / measure sequencer and edge counters
// for N_CH ring-oscillator odometer channels (each a ref RO and a stressed RO).
// Optional feature macro: RO_ODO_CONT_EN (continuous re-run after each drain).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        run request (ignored while busy), return-to-idle
//   stress_cycles       stress duration, latched on accepted start
//   cont_mode           re-run request (only with RO_ODO_CONT_EN)
//   ref_ro_out/str_ro_out  raw RO outputs, asynchronous to clk
//   ref_ctrl/str_ctrl   per-channel {ro_sleep,en_ro,en_trans,nmos_g}
//   busy, done          not-idle flag, end-of-run pulse
//   res_valid/res_ready result beat handshake
//   res_ch, res_ref_cnt, res_str_cnt, res_delta, res_sat  beat payload
module ro_odometer_ctrl #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int STRESS_W      = 32,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [STRESS_W-1:0] stress_cycles,
  input  logic                cont_mode,
  input  logic [N_CH-1:0]     ref_ro_out,
  input  logic [N_CH-1:0]     str_ro_out,
  output logic [4*N_CH-1:0]   ref_ctrl,
  output logic [4*N_CH-1:0]   str_ctrl,
  output logic                busy,
  output logic                done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_ch,
  output logic [CNT_W-1:0]    res_ref_cnt,
  output logic [CNT_W-1:0]    res_str_cnt,
  output logic [CNT_W:0]      res_delta,
  output logic                res_sat
);

  localparam int TW = (STRESS_W > 32) ? STRESS_W : 32;

  localparam logic [3:0] M_IDLE  = 4'b1010;
  localparam logic [3:0] M_RUN   = 4'b1110;
  localparam logic [3:0] M_SLEEP = 4'b0000;
  localparam logic [3:0] M_STR   = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE, S_STRESS, S_SETTLE, S_MEAS, S_DRAIN
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [CH_W-1:0] ch_idx, ch_nxt;
  logic            done_nxt;
  logic            hs, last;

  logic [N_CH-1:0] ref_s1, ref_s2, ref_d;
  logic [N_CH-1:0] str_s1, str_s2, str_d;
  logic [N_CH-1:0] ref_edge, str_edge;
  logic [CNT_W-1:0] ref_cnt [N_CH];
  logic [CNT_W-1:0] str_cnt [N_CH];

  logic [3:0] ref_mode, str_mode;

`ifdef RO_ODO_CONT_EN
  logic [STRESS_W-1:0] stress_lat;
  logic                lat_ld;
`else
  logic unused_cont;
  assign unused_cont = cont_mode;
`endif

  assign hs   = res_valid && res_ready;
  assign last = (ch_idx == CH_W'(N_CH-1));

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    ch_nxt    = ch_idx;
    done_nxt  = 1'b0;
`ifdef RO_ODO_CONT_EN
    lat_ld    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
`ifdef RO_ODO_CONT_EN
          lat_ld = 1'b1;
`endif
          if (stress_cycles == '0) begin
            state_nxt = S_SETTLE;
            tmr_nxt   = TW'(SETTLE_CYCLES-1);
          end else begin
            state_nxt = S_STRESS;
            tmr_nxt   = TW'(stress_cycles) - 1'b1;
          end
        end
      end
      S_STRESS: begin
        if (tmr == '0) begin
          state_nxt = S_SETTLE;
          tmr_nxt   = TW'(SETTLE_CYCLES-1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          state_nxt = S_MEAS;
          tmr_nxt   = TW'(GATE_CYCLES-1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_MEAS: begin
        if (tmr == '0) begin
          state_nxt = S_DRAIN;
          ch_nxt    = '0;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_DRAIN: begin
        if (hs) begin
          if (last) begin
            done_nxt  = 1'b1;
            ch_nxt    = '0;
            state_nxt = S_IDLE;
`ifdef RO_ODO_CONT_EN
            if (cont_mode) begin
              if (stress_lat == '0) begin
                state_nxt = S_SETTLE;
                tmr_nxt   = TW'(SETTLE_CYCLES-1);
              end else begin
                state_nxt = S_STRESS;
                tmr_nxt   = TW'(stress_lat) - 1'b1;
              end
            end
`endif
          end else begin
            ch_nxt = ch_idx + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort wins over every transition, including a same-cycle start
    if (abort) begin
      state_nxt = S_IDLE;
      ch_nxt    = '0;
      done_nxt  = 1'b0;
`ifdef RO_ODO_CONT_EN
      lat_ld    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tmr    <= '0;
      ch_idx <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      ch_idx <= ch_nxt;
      done   <= done_nxt;
    end
  end

`ifdef RO_ODO_CONT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stress_lat <= '0;
    else if (lat_ld) stress_lat <= stress_cycles;
  end
`endif

  // 2-flop synchroniser plus history flop per RO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_s1 <= '0; ref_s2 <= '0; ref_d <= '0;
      str_s1 <= '0; str_s2 <= '0; str_d <= '0;
    end else begin
      ref_s1 <= ref_ro_out; ref_s2 <= ref_s1; ref_d <= ref_s2;
      str_s1 <= str_ro_out; str_s2 <= str_s1; str_d <= str_s2;
    end
  end

  assign ref_edge = ref_s2 & ~ref_d;
  assign str_edge = str_s2 & ~str_d;

  // saturating counters, cleared during SETTLE, enabled only in MEAS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        ref_cnt[i] <= '0;
        str_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (state == S_SETTLE) begin
          ref_cnt[i] <= '0;
          str_cnt[i] <= '0;
        end else if (state == S_MEAS) begin
          if (ref_edge[i] && ref_cnt[i] != '1)
            ref_cnt[i] <= ref_cnt[i] + 1'b1;
          if (str_edge[i] && str_cnt[i] != '1)
            str_cnt[i] <= str_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ref_mode = M_IDLE;
    str_mode = M_IDLE;
    unique case (state)
      S_STRESS: begin
        ref_mode = M_SLEEP;
        str_mode = M_STR;
      end
      S_SETTLE, S_MEAS: begin
        ref_mode = M_RUN;
        str_mode = M_RUN;
      end
      default: ;
    endcase
  end

  assign ref_ctrl = {N_CH{ref_mode}};
  assign str_ctrl = {N_CH{str_mode}};

  assign busy        = (state != S_IDLE);
  assign res_valid   = (state == S_DRAIN);
  assign res_ch      = ch_idx;
  assign res_ref_cnt = ref_cnt[ch_idx];
  assign res_str_cnt = str_cnt[ch_idx];
  assign res_delta   = $signed({1'b0, res_ref_cnt})
                     - $signed({1'b0, res_str_cnt});
  assign res_sat     = (res_ref_cnt == '1) || (res_str_cnt == '1);

endmodule

// File: tb/tb_ro_odometer_ctrl.sv
// tb_ro_odometer_ctrl: directed bench for ro_odometer_ctrl
// main instance CNT_W=16, second instance CNT_W=4 for saturation
`timescale 1ns/1ps
module tb_ro_odometer_ctrl;

  localparam int N_CH = 2;
  localparam int SW   = 32;
  localparam logic [3:0] M_RUN   = 4'b1110;
  localparam logic [3:0] M_SLEEP = 4'b0000;
  localparam logic [3:0] M_STR   = 4'b1001;
  localparam logic [7:0] C_IDLE  = 8'hAA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cont_mode = 1'b0;
  logic res_ready = 1'b0;
  logic [SW-1:0] stress_cycles = '0;

  logic ref_a = 1'b0;
  logic str_a = 1'b0;
  logic str_b = 1'b0;
  int   ref_hp = 40;
  logic [N_CH-1:0] ref_ro_out, str_ro_out;

  logic [7:0]  ref_ctrl, str_ctrl;
  logic        busy, done, res_valid, res_sat;
  logic [0:0]  res_ch;
  logic [15:0] res_ref_cnt, res_str_cnt;
  logic [16:0] res_delta;

  logic [7:0]  s_rctl, s_sctl;
  logic        s_busy, s_done, s_valid, s_sat;
  logic [0:0]  s_ch;
  logic [3:0]  s_ref, s_str;
  logic [4:0]  s_delta;

  assign ref_ro_out = {ref_a, ref_a};
  assign str_ro_out = {str_b, str_a};

  always #5 clk = ~clk;
  always #(ref_hp) ref_a = ~ref_a;
  always #50 str_a = ~str_a;
  always #80 str_b = ~str_b;

  ro_odometer_ctrl #(
    .N_CH(N_CH), .CNT_W(16), .GATE_CYCLES(1024),
    .SETTLE_CYCLES(16), .STRESS_W(SW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stress_cycles(stress_cycles), .cont_mode(cont_mode),
    .ref_ro_out(ref_ro_out), .str_ro_out(str_ro_out),
    .ref_ctrl(ref_ctrl), .str_ctrl(str_ctrl),
    .busy(busy), .done(done), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch),
    .res_ref_cnt(res_ref_cnt), .res_str_cnt(res_str_cnt),
    .res_delta(res_delta), .res_sat(res_sat)
  );

  ro_odometer_ctrl #(
    .N_CH(N_CH), .CNT_W(4), .GATE_CYCLES(1024),
    .SETTLE_CYCLES(16), .STRESS_W(SW)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stress_cycles(stress_cycles), .cont_mode(cont_mode),
    .ref_ro_out(ref_ro_out), .str_ro_out(str_ro_out),
    .ref_ctrl(s_rctl), .str_ctrl(s_sctl),
    .busy(s_busy), .done(s_done), .res_valid(s_valid),
    .res_ready(res_ready), .res_ch(s_ch),
    .res_ref_cnt(s_ref), .res_str_cnt(s_str),
    .res_delta(s_delta), .res_sat(s_sat)
  );

  int checks = 0;
  int errors = 0;

  int b_ch[$], b_ref[$], b_str[$], b_dl[$], b_sat[$];
  int sb_ref[$], sb_dl[$], sb_sat[$];
  int n_stress, n_bad, n_done, busy_gap;
  logic [3:0] first_str;

  task automatic chk(input string tag, input longint obs,
                     input longint exp, input longint tol = 0);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      errors++;
      $display("FAIL %s got %0d exp %0d tol %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input int s);
    stress_cycles = SW'(s);
    start = 1'b1;
  endtask

  task automatic collect(input int budget, input int runs,
                         input int stop_cont);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    b_ch.delete(); b_ref.delete(); b_str.delete();
    b_dl.delete(); b_sat.delete();
    sb_ref.delete(); sb_dl.delete(); sb_sat.delete();
    n_stress = 0; n_bad = 0; n_done = 0; busy_gap = 0;
    first_str = 4'hF;
    while (n_done < runs && cyc < budget) begin
      tick();
      start = 1'b0;
      cyc++;
      if (busy && !seen) begin
        seen = 1'b1;
        first_str = str_ctrl[3:0];
      end
      if (str_ctrl[3:0] == M_STR) begin
        n_stress++;
        if (ref_ctrl[3:0] != M_SLEEP) n_bad++;
      end
      if (res_valid && res_ready) begin
        b_ch.push_back(int'(res_ch));
        b_ref.push_back(int'(res_ref_cnt));
        b_str.push_back(int'(res_str_cnt));
        b_dl.push_back(int'($signed(res_delta)));
        b_sat.push_back(int'(res_sat));
        sb_ref.push_back(int'(s_ref));
        sb_dl.push_back(int'($signed(s_delta)));
        sb_sat.push_back(int'(s_sat));
      end
      if (done) n_done++;
      if (seen && !busy && n_done < runs) busy_gap++;
      if (n_done >= stop_cont) cont_mode = 1'b0;
    end
    chk("ndone", n_done, runs);
    chk("busy_gap", busy_gap, 0);
  endtask

  initial begin
    int unstable, cap_ref, cap_str, seen_v, seen_d, k;

    // reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rctl", ref_ctrl, C_IDLE);
    chk("rst_sctl", str_ctrl, C_IDLE);
    chk("rst_ref", res_ref_cnt, 0);
    chk("rst_delta", res_delta, 0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_busy", busy, 0);
    chk("idle_sctl", str_ctrl, C_IDLE);

    // basic run
    res_ready = 1'b1;
    go(100);
    collect(3000, 1, 99);
    chk("stress_len", n_stress, 100);
    chk("ref_sleep", n_bad, 0);
    chk("first_ctrl", first_str, M_STR);
    chk("nbeats", b_ch.size(), 2);
    if (b_ch.size() == 2) begin
      chk("ch0", b_ch[0], 0);
      chk("ch1", b_ch[1], 1);
      chk("ref0", b_ref[0], 128, 1);
      chk("str0", b_str[0], 102, 1);
      chk("dl0", b_dl[0], 26, 2);
      chk("sat0", b_sat[0], 0);
      chk("ref1", b_ref[1], 128, 1);
      chk("str1", b_str[1], 64, 1);
      chk("dl1", b_dl[1], 64, 2);
      chk("s4_ref0", sb_ref[0], 15);
      chk("s4_sat0", sb_sat[0], 1);
    end
    chk("end_busy", busy, 0);
    chk("end_valid", res_valid, 0);
    tick();
    chk("done_1cyc", done, 0);

    // backpressure
    res_ready = 1'b0;
    go(3);
    k = 0;
    while (!res_valid && k < 2000) begin
      tick();
      start = 1'b0;
      k++;
    end
    chk("bp_valid", res_valid, 1);
    chk("bp_ch0", res_ch, 0);
    cap_ref = int'(res_ref_cnt);
    cap_str = int'(res_str_cnt);
    chk("bp_ref0", cap_ref, 128, 1);
    unstable = 0;
    repeat (20) begin
      tick();
      if (!res_valid || res_ch != 1'b0 ||
          int'(res_ref_cnt) != cap_ref ||
          int'(res_str_cnt) != cap_str) unstable++;
    end
    chk("bp_stable", unstable, 0);
    res_ready = 1'b1;
    tick();
    chk("bp_ch1", res_ch, 1);
    chk("bp_v1", res_valid, 1);
    chk("bp_str1", res_str_cnt, 64, 1);
    tick();
    chk("bp_done", done, 1);
    chk("bp_vlow", res_valid, 0);

    // zero stress skips STRESS
    go(0);
    collect(3000, 1, 99);
    chk("z_stress", n_stress, 0);
    chk("z_first", first_str, M_RUN);
    chk("z_beats", b_ch.size(), 2);

    // saturation
    ref_hp = 20;
    tick(20);
    go(0);
    collect(3000, 1, 99);
    if (b_ch.size() == 2) begin
      chk("sat_ref16", b_ref[0], 256, 1);
      chk("sat_ref4", sb_ref[0], 15);
      chk("sat_flag", sb_sat[0], 1);
      chk("sat_dl", sb_dl[0], 0);
      chk("sat_n16", b_sat[0], 0);
    end else begin
      chk("sat_beats", b_ch.size(), 2);
    end
    ref_hp = 40;
    tick(20);

    // abort in MEAS
    go(5);
    tick();
    start = 1'b0;
    tick(220);
    chk("ab_pre", str_ctrl[3:0], M_RUN);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_ctrl", str_ctrl, C_IDLE);
    chk("ab_valid", res_valid, 0);
    seen_v = 0;
    seen_d = 0;
    repeat (1200) begin
      tick();
      if (res_valid) seen_v++;
      if (done) seen_d++;
    end
    chk("ab_nobeat", seen_v, 0);
    chk("ab_nodone", seen_d, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("ab_start", busy, 0);

    // reset during STRESS
    go(200);
    tick();
    start = 1'b0;
    tick(10);
    chk("rs_pre", str_ctrl[3:0], M_STR);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_rctl", ref_ctrl, C_IDLE);
    chk("rs_sctl", str_ctrl, C_IDLE);
    tick();
    rst_n = 1'b1;
    seen_v = 0;
    seen_d = 0;
    repeat (300) begin
      tick();
      if (res_valid || busy) seen_v++;
      if (done) seen_d++;
    end
    chk("rs_quiet", seen_v, 0);
    chk("rs_nodone", seen_d, 0);

`ifdef RO_ODO_CONT_EN
    // continuous: three back-to-back runs
    cont_mode = 1'b1;
    go(10);
    collect(5000, 3, 2);
    chk("c_beats", b_ch.size(), 6);
    chk("c_stress", n_stress, 30);
    tick(2);
    chk("c_idle", busy, 0);
`else
    // cont_mode has no effect without the feature
    cont_mode = 1'b1;
    go(0);
    collect(3000, 1, 99);
    tick(2);
    chk("c_ign", busy, 0);
    cont_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
